cla_multiword_seq: RTL and testbench

- Multi-cycle add/subtract sequencer for wide operands.
- Splits the TOTAL_W-bit operands into NCHUNK = TOTAL_W/CHUNK_W chunks, LSB chunk first.
- Processes one chunk per cycle through a single narrow CLA instance and chains the carry through a register.
- Sits between a requester (valid/ready) and a consumer (valid/ready), trading latency for adder area.

---
 rtl/cla_multiword_seq.sv | 148 ++++++++++++++
 tb/tb_cla_multiword_seq.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_multiword_seq.sv
// Multi-cycle wide add/subtract: one narrow carry-lookahead adder is reused
// across NCHUNK cycles, LSB chunk first, with the carry held in a register.
module cla_multiword_seq #(
  parameter int TOTAL_W = 32,
  parameter int CHUNK_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [TOTAL_W-1:0] in_a,
  input  logic [TOTAL_W-1:0] in_b,
  input  logic               in_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TOTAL_W-1:0] out_result,
  output logic               out_carry,
  output logic               out_overflow,
  output logic               busy
);

  localparam int NCHUNK = TOTAL_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CLA_W  = CHUNK_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK_W < 1) || (TOTAL_W % CHUNK_W != 0)) begin : g_bad_width
      $error("TOTAL_W must be an integer multiple of CHUNK_W");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [TOTAL_W-1:0] a_reg;
  logic [TOTAL_W-1:0] b_reg;
  logic [TOTAL_W-1:0] result_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   cnt;
  int                 base;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CLA_W-1:0]   cla_x;
  logic [CLA_W-1:0]   cla_y;
  logic [CLA_W-1:0]   gen;
  logic [CLA_W-1:0]   prop;
  logic [CLA_W:0]     carry_vec;
  logic [CLA_W:0]     cla_sum;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;

  assign base    = int'(cnt) * CHUNK_W;
  assign a_chunk = a_reg[base +: CHUNK_W];
  assign b_chunk = b_reg[base +: CHUNK_W];

  // Extra LSB column {1, carry_reg} injects the chained carry into a zero-carry-in CLA.
  assign cla_x = {a_chunk, 1'b1};
  assign cla_y = {b_chunk, carry_reg};

  always_comb begin
    logic [CLA_W-1:0] span;
    logic             c_acc;
    span      = '0;
    c_acc     = 1'b0;
    gen       = cla_x & cla_y;
    prop      = cla_x ^ cla_y;
    carry_vec = '0;
    // Each carry is a flat sum of products of generates and propagate runs.
    for (int i = 0; i < CLA_W; i++) begin
      c_acc = gen[i];
      for (int j = 0; j < i; j++) begin
        span = '0;
        for (int k = j + 1; k <= i; k++) span[k] = 1'b1;
        c_acc = c_acc | (gen[j] & (&(prop | ~span)));
      end
      carry_vec[i+1] = c_acc;
    end
    cla_sum = {carry_vec[CLA_W], prop ^ carry_vec[CLA_W-1:0]};
  end

  assign chunk_sum  = cla_sum[CHUNK_W:1];
  assign chunk_cout = cla_sum[CHUNK_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg     <= in_a;
          b_reg     <= in_sub ? ~in_b : in_b;
          carry_reg <= in_sub;
          cnt       <= '0;
        end
        RUN: begin
          result_reg[base +: CHUNK_W] <= chunk_sum;
          carry_reg                   <= chunk_cout;
          cnt                         <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds its outputs until taken.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    out_result   = result_reg;
    out_carry    = 1'b0;
    out_overflow = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) state_next = DONE;
      end
      DONE: begin
        busy         = 1'b1;
        out_valid    = 1'b1;
        out_carry    = carry_reg;
        out_overflow = (a_reg[TOTAL_W-1] == b_reg[TOTAL_W-1]) &&
                       (result_reg[TOTAL_W-1] != a_reg[TOTAL_W-1]);
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cla_multiword_seq.sv
// Directed and randomised checks of cla_multiword_seq in three shapes:
// (32,8), (16,4) and (8,8).
module tb_cla_multiword_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] t_a [3];
  logic [31:0] t_b [3];
  logic [2:0]  t_valid;
  logic [2:0]  t_sub;
  logic [2:0]  t_oready;
  wire  [2:0]  iready;
  wire  [2:0]  ovalid;
  wire  [2:0]  ocarry;
  wire  [2:0]  oovf;
  wire  [2:0]  obusy;
  wire  [31:0] res0;
  wire  [15:0] res1;
  wire  [7:0]  res2;

  int checks;
  int errors;
  logic [33:0] exp_q[$];

  cla_multiword_seq #(.TOTAL_W(32), .CHUNK_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid[0]), .in_ready(iready[0]),
    .in_a(t_a[0]), .in_b(t_b[0]), .in_sub(t_sub[0]), .out_valid(ovalid[0]),
    .out_ready(t_oready[0]), .out_result(res0), .out_carry(ocarry[0]),
    .out_overflow(oovf[0]), .busy(obusy[0]));

  cla_multiword_seq #(.TOTAL_W(16), .CHUNK_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid[1]), .in_ready(iready[1]),
    .in_a(t_a[1][15:0]), .in_b(t_b[1][15:0]), .in_sub(t_sub[1]), .out_valid(ovalid[1]),
    .out_ready(t_oready[1]), .out_result(res1), .out_carry(ocarry[1]),
    .out_overflow(oovf[1]), .busy(obusy[1]));

  cla_multiword_seq #(.TOTAL_W(8), .CHUNK_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(t_valid[2]), .in_ready(iready[2]),
    .in_a(t_a[2][7:0]), .in_b(t_b[2][7:0]), .in_sub(t_sub[2]), .out_valid(ovalid[2]),
    .out_ready(t_oready[2]), .out_result(res2), .out_carry(ocarry[2]),
    .out_overflow(oovf[2]), .busy(obusy[2]));

  function automatic logic [31:0] get_res(input int d);
    case (d)
      0:       return res0;
      1:       return {16'h0, res1};
      default: return {24'h0, res2};
    endcase
  endfunction

  // One request, latency measured in edges after the accept edge, then result taken.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] res, output logic c, output logic o, output int lat);
    int guard;
    @(negedge clk);
    t_a[d] = a; t_b[d] = b; t_sub[d] = sub; t_oready[d] = 1'b0; t_valid[d] = 1'b1;
    guard = 0;
    while (!iready[d] && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    t_valid[d] = 1'b0;
    lat = 0;
    while (!ovalid[d] && lat < 50) begin @(negedge clk); lat++; end
    res = get_res(d); c = ocarry[d]; o = oovf[d];
    t_oready[d] = 1'b1;
    @(negedge clk);
    t_oready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t_valid = '0; t_sub = '0; t_oready = '0;
    for (int d = 0; d < 3; d++) begin t_a[d] = '0; t_b[d] = '0; end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({iready[d], ovalid[d], ocarry[d], oovf[d], obusy[d]} !== 5'b10000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got %b expected 10000", d,
                 {iready[d], ovalid[d], ocarry[d], oovf[d], obusy[d]});
      end
      checks++;
      if (get_res(d) !== 32'h0) begin
        errors++;
        $display("FAIL reset_result dut%0d: got %h expected 0", d, get_res(d));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (iready[0] !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 1", iready[0]);
    end
  endtask

  task automatic test_directed();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    logic [5:0]  vs, vc, vo;
    logic [31:0] res;
    logic        c, o;
    int          lat;
    va = '{32'hFFFFFFFF, 32'd5, 32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h12345678};
    vb = '{32'h00000001, 32'd7, 32'd5, 32'h00000001, 32'h00000001, 32'h89ABCDEF};
    vr = '{32'h00000000, 32'hFFFFFFFE, 32'h00000002, 32'h80000000, 32'h7FFFFFFF, 32'h9BE02467};
    vs = 6'b010110;
    vc = 6'b010101;
    vo = 6'b011000;
    for (int i = 0; i < 6; i++) begin
      run_op(0, va[i], vb[i], vs[i], res, c, o, lat);
      checks++;
      if (res !== vr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, res, vr[i]);
      end
      checks++;
      if ({c, o} !== {vc[i], vo[i]}) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got c=%b o=%b expected c=%b o=%b", i, c, o, vc[i], vo[i]);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected 4", i, lat);
      end
    end
  endtask

  task automatic test_narrow();
    logic [31:0] res;
    logic        c, o;
    int          lat;
    run_op(1, 32'h8000, 32'h0001, 1'b1, res, c, o, lat);
    checks++;
    if ({res, c, o, lat} !== {32'h7FFF, 1'b1, 1'b1, 32'd4}) begin
      errors++;
      $display("FAIL narrow16_sub: got %h c=%b o=%b lat=%0d expected 7fff c=1 o=1 lat=4", res, c, o, lat);
    end
    run_op(1, 32'hFFFF, 32'h0001, 1'b0, res, c, o, lat);
    checks++;
    if ({res, c, o} !== {32'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL narrow16_add: got %h c=%b o=%b expected 0000 c=1 o=0", res, c, o);
    end
    run_op(2, 32'hFF, 32'h01, 1'b0, res, c, o, lat);
    checks++;
    if ({res, c, o, lat} !== {32'h00, 1'b1, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL single_chunk_wrap: got %h c=%b o=%b lat=%0d expected 00 c=1 o=0 lat=1", res, c, o, lat);
    end
    run_op(2, 32'h7F, 32'h01, 1'b0, res, c, o, lat);
    checks++;
    if ({res, c, o} !== {32'h80, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_chunk_ovf: got %h c=%b o=%b expected 80 c=0 o=1", res, c, o);
    end
    run_op(2, 32'h05, 32'h07, 1'b1, res, c, o, lat);
    checks++;
    if ({res, c, o} !== {32'hFE, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_chunk_sub: got %h c=%b o=%b expected fe c=0 o=0", res, c, o);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    @(negedge clk);
    t_a[0] = 32'h0000FFFF; t_b[0] = 32'h00000001; t_sub[0] = 1'b0;
    t_oready[0] = 1'b0; t_valid[0] = 1'b1;
    guard = 0;
    while (!iready[0] && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    t_valid[0] = 1'b0;
    guard = 0;
    while (!ovalid[0] && guard < 50) begin @(negedge clk); guard++; end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res0 !== 32'h00010000) begin
        errors++;
        $display("FAIL stall_result[%0d]: got %h expected 00010000", k, res0);
      end
      checks++;
      if ({ovalid[0], iready[0], obusy[0], ocarry[0], oovf[0]} !== 5'b10100) begin
        errors++;
        $display("FAIL stall_flags[%0d]: got %b expected 10100", k,
                 {ovalid[0], iready[0], obusy[0], ocarry[0], oovf[0]});
      end
      t_a[0] = $urandom; t_b[0] = $urandom; t_sub[0] = 1'b1; t_valid[0] = 1'b1;
      @(negedge clk);
    end
    t_valid[0] = 1'b0;
    t_oready[0] = 1'b1;
    @(negedge clk);
    t_oready[0] = 1'b0;
    checks++;
    if ({iready[0], ovalid[0], obusy[0]} !== 3'b100) begin
      errors++;
      $display("FAIL stall_release: got ready/valid/busy %b expected 100",
               {iready[0], ovalid[0], obusy[0]});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic        c, o;
    int          lat;
    int          guard;
    @(negedge clk);
    t_a[0] = 32'h01020304; t_b[0] = 32'h10203040; t_sub[0] = 1'b0; t_valid[0] = 1'b1;
    guard = 0;
    while (!iready[0] && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    t_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({iready[0], ovalid[0], obusy[0], ocarry[0], oovf[0]} !== 5'b10000) begin
      errors++;
      $display("FAIL midrun_reset_flags: got %b expected 10000",
               {iready[0], ovalid[0], obusy[0], ocarry[0], oovf[0]});
    end
    checks++;
    if (res0 !== 32'h0) begin
      errors++;
      $display("FAIL midrun_reset_result: got %h expected 0", res0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (ovalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_emit: got out_valid %b expected 0", ovalid[0]);
    end
    run_op(0, 32'd3, 32'd4, 1'b0, res, c, o, lat);
    checks++;
    if ({res, c, o, lat} !== {32'd7, 1'b0, 1'b0, 32'd4}) begin
      errors++;
      $display("FAIL after_reset_op: got %h c=%b o=%b lat=%0d expected 7 c=0 o=0 lat=4", res, c, o, lat);
    end
  endtask

  task automatic test_random(input int d, input int w, input int n);
    longint unsigned mask;
    int got;
    int cyc;
    mask = (64'd1 << w) - 1;
    exp_q.delete();
    got = 0;
    t_oready[d] = 1'b0;
    fork
      begin
        longint unsigned a, b, full, r;
        longint sa, sb, sr, smax, smin;
        logic sub, c, o;
        int guard;
        smax = longint'(mask >> 1);
        smin = -smax - 1;
        for (int k = 0; k < n; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          case ($urandom_range(0, 5))
            0:       a = mask;
            1:       a = mask >> 1;
            2:       a = (mask >> 1) + 1;
            default: a = {$urandom, $urandom} & mask;
          endcase
          case ($urandom_range(0, 5))
            0:       b = 1;
            1:       b = mask;
            2:       b = (mask >> 1) + 1;
            default: b = {$urandom, $urandom} & mask;
          endcase
          sub = 1'($urandom_range(0, 1));
          sa = a[w-1] ? longint'(a) - longint'(mask) - 1 : longint'(a);
          sb = b[w-1] ? longint'(b) - longint'(mask) - 1 : longint'(b);
          if (sub) begin
            r  = (a - b) & mask;
            c  = (a >= b);
            sr = sa - sb;
          end else begin
            full = a + b;
            r    = full & mask;
            c    = (full > mask);
            sr   = sa + sb;
          end
          o = (sr > smax) || (sr < smin);
          exp_q.push_back({o, c, r[31:0]});
          t_a[d] = a[31:0]; t_b[d] = b[31:0]; t_sub[d] = sub; t_valid[d] = 1'b1;
          guard = 0;
          while (!iready[d] && guard < 300) begin @(negedge clk); guard++; end
          @(negedge clk);
          t_valid[d] = 1'b0;
        end
      end
      begin
        logic [33:0] e, act;
        cyc = 0;
        while (got < n && cyc < 30000) begin
          @(negedge clk);
          cyc++;
          t_oready[d] = ($urandom_range(0, 3) != 0);
          if (ovalid[d] && t_oready[d]) begin
            checks++;
            act = {oovf[d], ocarry[d], get_res(d)};
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL random_extra dut%0d: got %h with nothing outstanding", d, act);
            end else begin
              e = exp_q.pop_front();
              if (act !== e) begin
                errors++;
                $display("FAIL random_op dut%0d #%0d: got o/c/res %h expected %h", d, got, act, e);
              end
            end
            got++;
          end
        end
      end
    join
    t_oready[d] = 1'b0;
    checks++;
    if (got != n || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_count dut%0d: got %0d results, %0d left, expected %0d and 0",
               d, got, exp_q.size(), n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_narrow();
    test_backpressure();
    test_reset_mid();
    test_random(0, 32, 600);
    test_random(1, 16, 600);
    test_random(2, 8, 600);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
